// File: rtl/uart_rx_block_assembler_if.sv
// uart_rx_block_assembler_if: byte-strobe input, block handshake output and status pulses.
interface uart_rx_block_assembler_if #(parameter int BLOCK_BYTES = 16);
  logic                               rx_done;
  logic [7:0]                         rx_data;
  logic [8*BLOCK_BYTES-1:0]           block_data;
  logic                               block_valid;
  logic                               block_ready;
  logic [$clog2(BLOCK_BYTES+1)-1:0]   byte_count;
  logic                               overrun;
  logic                               timeout;
  modport master (output rx_done, rx_data, block_ready,
                  input  block_data, block_valid, byte_count, overrun, timeout);
  modport slave  (input  rx_done, rx_data, block_ready,
                  output block_data, block_valid, byte_count, overrun, timeout);
endinterface

// File: rtl/uart_rx_block_assembler.sv
// uart_rx_block_assembler: packs UART byte strobes into fixed-size blocks, with gap timeout and overrun reporting.
module uart_rx_block_assembler #(
  parameter int BLOCK_BYTES  = 16,
  parameter int TIMEOUT_CLKS = 50000,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  uart_rx_block_assembler_if.slave  bus
);
  localparam int CW = $clog2(BLOCK_BYTES + 1);
  localparam int IW = $clog2(BLOCK_BYTES);
  typedef enum logic {FILL, HOLD} state_e;
  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [CNT_W-1:0]         tmr_q, tmr_d;
  logic [8*BLOCK_BYTES-1:0] data_q, data_d;
  logic                     valid_q, valid_d, ovr_q, ovr_d, to_q, to_d;
  logic                     xfer, wr;
  logic [IW-1:0]            pos;
  // A byte arriving with the handshake becomes slot 0 of the next block.
  always_comb begin
    xfer    = valid_q & bus.block_ready;
    wr      = bus.rx_done & (state_q == FILL | xfer);
    pos     = IW'(BLOCK_BYTES - 1) - (state_q == HOLD ? '0 : cnt_q[IW-1:0]);
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    to_d    = 1'b0;
    if (wr) data_d[{pos, 3'b000} +: 8] = bus.rx_data;
    if (state_q == HOLD) begin
      ovr_d = bus.rx_done & ~xfer;
      if (xfer) begin
        state_d = FILL;
        valid_d = 1'b0;
        cnt_d   = wr ? CW'(1) : '0;
      end
    end else if (wr) begin
      cnt_d = cnt_q + CW'(1);
      tmr_d = '0;
      if (cnt_q == CW'(BLOCK_BYTES - 1)) begin
        state_d = HOLD;
        valid_d = 1'b1;
      end
    end else if (cnt_q != '0) begin
      if (tmr_q == CNT_W'(TIMEOUT_CLKS - 1)) begin
        cnt_d = '0;
        tmr_d = '0;
        to_d  = 1'b1;
      end else begin
        tmr_d = tmr_q + CNT_W'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      tmr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
    end
  end
  assign bus.block_data  = data_q;
  assign bus.block_valid = valid_q;
  assign bus.byte_count  = cnt_q;
  assign bus.overrun     = ovr_q;
  assign bus.timeout     = to_q;
endmodule

// File: tb/tb_uart_rx_block_assembler.sv
// tb_uart_rx_block_assembler: directed scenarios plus random traffic against a byte-queue reference model.
module tb_uart_rx_block_assembler;
  localparam int N  = 16;
  localparam int TO = 40;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  byte unsigned m_q[$];
  int m_idle = 0;
  logic m_ovr = 1'b0, m_to = 1'b0;
  uart_rx_block_assembler_if #(.BLOCK_BYTES(N)) bus ();
  uart_rx_block_assembler #(.BLOCK_BYTES(N), .TIMEOUT_CLKS(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  function automatic logic [8*N-1:0] m_blk();
    logic [8*N-1:0] r = '0;
    foreach (m_q[i]) r[8*(N-1-i) +: 8] = m_q[i];
    return r;
  endfunction
  task automatic m_reset();
    m_q.delete();
    m_idle = 0;
    m_ovr  = 1'b0;
    m_to   = 1'b0;
  endtask
  // One clock: drive inputs, apply the queue model to what the edge sampled, settle.
  task automatic step(input logic rd, input logic [7:0] d, input logic rdy);
    bus.rx_done = rd;
    bus.rx_data = d;
    bus.block_ready = rdy;
    @(posedge clk);
    m_ovr = 1'b0;
    m_to  = 1'b0;
    if (m_q.size() == N) begin
      if (rdy) begin
        m_q.delete();
        if (rd) m_q.push_back(d);
      end else if (rd) m_ovr = 1'b1;
      m_idle = 0;
    end else if (rd) begin
      m_q.push_back(d);
      m_idle = 0;
    end else if (m_q.size() > 0) begin
      if (m_idle == TO - 1) begin
        m_q.delete();
        m_idle = 0;
        m_to = 1'b1;
      end else m_idle++;
    end
    #1;
    bus.rx_done = 1'b0;
    bus.block_ready = 1'b0;
  endtask
  task automatic test_reset();
    bus.rx_done = 1'b0; bus.rx_data = 8'h00; bus.block_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++; if (bus.block_valid !== 1'b0 || bus.byte_count !== '0 || bus.overrun !== 1'b0 || bus.timeout !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got v=%b c=%0d o=%b t=%b exp 0", bus.block_valid, bus.byte_count, bus.overrun, bus.timeout); end
    checks++; if (bus.block_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.block_data); end
    @(negedge clk); rst_n = 1'b1;
    m_reset();
    step(0, 0, 0);
    checks++; if (bus.overrun !== 1'b0 || bus.timeout !== 1'b0 || bus.byte_count !== '0) begin
      errors++; $display("FAIL reset_release got o=%b t=%b c=%0d exp 0", bus.overrun, bus.timeout, bus.byte_count); end
  endtask
  task automatic test_full_block();
    for (int i = 0; i < N; i++) begin
      step(1, 8'(i), 0);
      if (i == N - 2) begin
        checks++; if (bus.block_valid !== 1'b0 || bus.byte_count !== 5'(N-1)) begin
          errors++; $display("FAIL full_early got v=%b c=%0d exp v=0 c=%0d", bus.block_valid, bus.byte_count, N-1); end
      end
    end
    checks++; if (bus.block_valid !== 1'b1) begin errors++; $display("FAIL full_valid got %b exp 1", bus.block_valid); end
    checks++; if (bus.block_data !== 128'h000102030405060708090A0B0C0D0E0F) begin
      errors++; $display("FAIL full_data got %h exp 000102030405060708090a0b0c0d0e0f", bus.block_data); end
    checks++; if (bus.byte_count !== 5'd16) begin errors++; $display("FAIL full_count got %0d exp 16", bus.byte_count); end
    step(0, 0, 1);
    checks++; if (bus.block_valid !== 1'b0 || bus.byte_count !== 5'd0) begin
      errors++; $display("FAIL full_accept got v=%b c=%0d exp 0 0", bus.block_valid, bus.byte_count); end
    step(0, 0, 1);
    checks++; if (bus.block_valid !== 1'b0 || bus.byte_count !== 5'd0) begin
      errors++; $display("FAIL ready_idle got v=%b c=%0d exp 0 0", bus.block_valid, bus.byte_count); end
  endtask
  task automatic test_timeout();
    int pulses = 0;
    for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0);
    for (int i = 0; i < TO + 5; i++) begin
      step(0, 0, 0);
      if (bus.timeout === 1'b1) pulses++;
      if (i == TO - 2) begin
        checks++; if (bus.byte_count !== 5'd5 || bus.timeout !== 1'b0) begin
          errors++; $display("FAIL timeout_early got c=%0d t=%b exp 5 0", bus.byte_count, bus.timeout); end
      end
      if (i == TO - 1) begin
        checks++; if (bus.timeout !== 1'b1 || bus.byte_count !== 5'd0) begin
          errors++; $display("FAIL timeout_fire got t=%b c=%0d exp 1 0", bus.timeout, bus.byte_count); end
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL timeout_pulses got %0d exp 1", pulses); end
    for (int i = 0; i < N; i++) step(1, 8'(8'hA0 + i), 0);
    checks++; if (bus.block_data !== 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF || bus.block_valid !== 1'b1) begin
      errors++; $display("FAIL timeout_clean got v=%b %h exp 1 a0a1..af", bus.block_valid, bus.block_data); end
    step(0, 0, 1);
  endtask
  task automatic test_expiry_race();
    for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0);
    for (int i = 0; i < TO - 1; i++) step(0, 0, 0);
    step(1, 8'h3C, 0);
    checks++; if (bus.timeout !== 1'b0 || bus.byte_count !== 5'd6) begin
      errors++; $display("FAIL race_expiry got t=%b c=%0d exp 0 6", bus.timeout, bus.byte_count); end
    step(0, 0, 0);
    checks++; if (bus.timeout !== 1'b0 || bus.byte_count !== 5'd6) begin
      errors++; $display("FAIL race_after got t=%b c=%0d exp 0 6", bus.timeout, bus.byte_count); end
    for (int i = 0; i < TO + 2; i++) step(0, 0, 0);
    checks++; if (bus.byte_count !== 5'(m_q.size())) begin
      errors++; $display("FAIL race_flush got %0d exp %0d", bus.byte_count, m_q.size()); end
  endtask
  task automatic test_overrun();
    logic [8*N-1:0] held;
    for (int i = 0; i < N; i++) step(1, 8'($urandom), 0);
    held = m_blk();
    step(1, 8'h55, 0);
    checks++; if (bus.overrun !== 1'b1 || bus.block_valid !== 1'b1 || bus.block_data !== held) begin
      errors++; $display("FAIL ovr_first got o=%b v=%b %h exp 1 1 %h", bus.overrun, bus.block_valid, bus.block_data, held); end
    step(0, 0, 0);
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_single got %b exp 0", bus.overrun); end
    step(1, 8'h66, 0);
    checks++; if (bus.overrun !== 1'b1 || bus.block_data !== held || bus.byte_count !== 5'd16) begin
      errors++; $display("FAIL ovr_second got o=%b c=%0d %h exp 1 16 %h", bus.overrun, bus.byte_count, bus.block_data, held); end
    step(0, 0, 1);
  endtask
  task automatic test_handshake_race();
    for (int i = 0; i < N; i++) step(1, 8'($urandom), 0);
    step(1, 8'h77, 1);
    checks++; if (bus.block_valid !== 1'b0 || bus.byte_count !== 5'd1 || bus.overrun !== 1'b0) begin
      errors++; $display("FAIL hs_race got v=%b c=%0d o=%b exp 0 1 0", bus.block_valid, bus.byte_count, bus.overrun); end
    for (int i = 1; i < N; i++) step(1, 8'($urandom), 0);
    checks++; if (bus.block_data[127:120] !== 8'h77 || bus.block_data !== m_blk() || bus.block_valid !== 1'b1) begin
      errors++; $display("FAIL hs_byte0 got v=%b %h exp 1 %h", bus.block_valid, bus.block_data, m_blk()); end
    step(0, 0, 1);
  endtask
  task automatic test_async_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < (pass == 0 ? 9 : N); i++) step(1, 8'($urandom), 0);
      #2 rst_n = 1'b0;
      #1;
      m_reset();
      checks++; if (bus.block_valid !== 1'b0 || bus.byte_count !== '0 || bus.block_data !== '0 || bus.overrun !== 1'b0 || bus.timeout !== 1'b0) begin
        errors++; $display("FAIL areset_%0d got v=%b c=%0d %h exp all 0", pass, bus.block_valid, bus.byte_count, bus.block_data); end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < N; i++) step(1, 8'($urandom), 0);
      checks++; if (bus.block_valid !== 1'b1 || bus.block_data !== m_blk() || bus.overrun !== 1'b0) begin
        errors++; $display("FAIL areset_clean_%0d got v=%b %h exp 1 %h", pass, bus.block_valid, bus.block_data, m_blk()); end
      step(0, 0, 1);
    end
  endtask
  task automatic test_random();
    for (int b = 0; b < 24; b++) begin
      int len = $urandom_range(0, 40);
      int gap = $urandom_range(0, TO + 5);
      for (int i = 0; i < len + gap; i++) begin
        if (i < len) step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0));
        else step(0, 0, 1'($urandom_range(0, 7) == 0));
        checks++; if (bus.block_valid !== (m_q.size() == N) || bus.byte_count !== 5'(m_q.size()) ||
                       bus.overrun !== m_ovr || bus.timeout !== m_to || (m_q.size() == N && bus.block_data !== m_blk())) begin
          errors++; $display("FAIL rand_%0d_%0d got v=%b c=%0d o=%b t=%b exp v=%b c=%0d o=%b t=%b", b, i,
            bus.block_valid, bus.byte_count, bus.overrun, bus.timeout, m_q.size() == N, m_q.size(), m_ovr, m_to); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_full_block();
    test_timeout();
    test_expiry_race();
    test_overrun();
    test_handshake_race();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
